// File: rtl/ram_store_rmw.sv
// rtl/ram_store_rmw.sv - sub-word store unit doing read-modify-write on a single-port data RAM
// Full-word stores write directly; narrower stores fetch the word, merge the lanes and write back.
module ram_store_rmw #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 11,
  parameter int RD_LAT = 1,
  localparam int NB    = DATA_W / 8,
  localparam int OFF_W = $clog2(DATA_W / 8)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [ADDR_W+OFF_W-1:0] req_addr,
  input  logic [2:0]              req_size,
  input  logic [DATA_W-1:0]       req_data,
  output logic [ADDR_W-1:0]       ram_addr,
  output logic                    ram_rd_en,
  input  logic [DATA_W-1:0]       ram_rd_data,
  output logic                    ram_wr_en,
  output logic [DATA_W-1:0]       ram_wr_data,
  output logic                    done,
  output logic                    misalign_err
);

  typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, ERR} state_t;

  state_t              state_q, state_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [OFF_W-1:0]    off_q, off_d;
  logic [2:0]          size_q, size_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic                rd_en_q, rd_en_d;
  logic                wr_en_q, wr_en_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic                done_q, done_d;
  logic                mis_q, mis_d;

  logic [OFF_W-1:0]    req_off;
  logic                req_bad;
  logic                req_full;
  logic [DATA_W-1:0]   shifted;
  logic [DATA_W-1:0]   merged;

  assign req_off  = req_addr[OFF_W-1:0];
  assign req_bad  = (int'(req_size) > OFF_W) ||
                    ((int'(req_off) & ((1 << req_size) - 1)) != 0);
  assign req_full = (int'(req_size) == OFF_W);

  // Lanes [off, off + 2^size) take the store data; the rest keep the fetched RAM bytes.
  always_comb begin
    shifted = data_q << {off_q, 3'b000};
    merged  = ram_rd_data;
    for (int b = 0; b < NB; b++) begin
      if (b >= int'(off_q) && b < int'(off_q) + (1 << size_q)) begin
        merged[b*8 +: 8] = shifted[b*8 +: 8];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    off_d      = off_q;
    size_d     = size_q;
    data_d     = data_q;
    ram_addr_d = ram_addr_q;
    wr_data_d  = wr_data_q;
    rd_en_d    = 1'b0;
    wr_en_d    = 1'b0;
    done_d     = 1'b0;
    mis_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          off_d  = req_off;
          size_d = req_size;
          data_d = req_data;
          if (req_bad) begin
            state_d = ERR;
            done_d  = 1'b1;
            mis_d   = 1'b1;
          end else begin
            ram_addr_d = req_addr[ADDR_W+OFF_W-1:OFF_W];
            if (req_full) begin
              state_d   = WRITE;
              wr_en_d   = 1'b1;
              done_d    = 1'b1;
              wr_data_d = req_data;
            end else begin
              state_d = READ;
              rd_en_d = 1'b1;
            end
          end
        end
      end
      READ: begin
        cnt_d   = 3'(RD_LAT);
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q - 3'd1;
        // Read data is valid exactly in the final wait cycle.
        if (cnt_q == 3'd1) begin
          state_d   = WRITE;
          wr_en_d   = 1'b1;
          done_d    = 1'b1;
          wr_data_d = merged;
        end
      end
      WRITE:   state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      off_q      <= '0;
      size_q     <= '0;
      data_q     <= '0;
      ram_addr_q <= '0;
      rd_en_q    <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_data_q  <= '0;
      done_q     <= 1'b0;
      mis_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      off_q      <= off_d;
      size_q     <= size_d;
      data_q     <= data_d;
      ram_addr_q <= ram_addr_d;
      rd_en_q    <= rd_en_d;
      wr_en_q    <= wr_en_d;
      wr_data_q  <= wr_data_d;
      done_q     <= done_d;
      mis_q      <= mis_d;
    end
  end

  assign req_ready    = (state_q == IDLE);
  assign ram_addr     = ram_addr_q;
  assign ram_rd_en    = rd_en_q;
  assign ram_wr_en    = wr_en_q;
  assign ram_wr_data  = wr_data_q;
  assign done         = done_q;
  assign misalign_err = mis_q;

endmodule

// File: tb/tb_ram_store_rmw.sv
// tb/tb_ram_store_rmw.sv - directed-vector bench for ram_store_rmw (32-bit/lat 1 and 64-bit/lat 3)
module tb_ram_store_rmw;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        v32 = 1'b0, v64 = 1'b0;
  logic [13:0] addr = '0;
  logic [2:0]  size = '0;
  logic [63:0] data = '0;
  logic        sel = 1'b0;

  logic        rdy32, rd32, wr32, done32, mis32;
  logic [10:0] ra32;
  logic [31:0] wd32, rdd32, ram32_word;
  logic        rdy64, rd64, wr64, done64, mis64;
  logic [10:0] ra64;
  logic [63:0] wd64, rdd64, ram64_word, p0, p1;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  ram_store_rmw #(.DATA_W(32), .ADDR_W(11), .RD_LAT(1)) u32 (
    .clk(clk), .reset(reset), .req_valid(v32), .req_ready(rdy32),
    .req_addr(addr[12:0]), .req_size(size), .req_data(data[31:0]),
    .ram_addr(ra32), .ram_rd_en(rd32), .ram_rd_data(rdd32),
    .ram_wr_en(wr32), .ram_wr_data(wd32), .done(done32), .misalign_err(mis32)
  );

  ram_store_rmw #(.DATA_W(64), .ADDR_W(11), .RD_LAT(3)) u64 (
    .clk(clk), .reset(reset), .req_valid(v64), .req_ready(rdy64),
    .req_addr(addr), .req_size(size), .req_data(data),
    .ram_addr(ra64), .ram_rd_en(rd64), .ram_rd_data(rdd64),
    .ram_wr_en(wr64), .ram_wr_data(wd64), .done(done64), .misalign_err(mis64)
  );

  // Behavioural RAM read ports: latency 1 and latency 3, zero when not read.
  always @(posedge clk) rdd32 <= rd32 ? ram32_word : 32'h0;
  always @(posedge clk) begin
    p0    <= rd64 ? ram64_word : 64'h0;
    p1    <= p0;
    rdd64 <= p1;
  end

  logic        o_rd, o_wr, o_done, o_mis, o_rdy;
  logic [63:0] o_wd, o_addr;
  always_comb begin
    o_rd   = sel ? rd64   : rd32;
    o_wr   = sel ? wr64   : wr32;
    o_done = sel ? done64 : done32;
    o_mis  = sel ? mis64  : mis32;
    o_rdy  = sel ? rdy64  : rdy32;
    o_wd   = sel ? wd64   : {32'h0, wd32};
    o_addr = sel ? {53'h0, ra64} : {53'h0, ra32};
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Issue one request and watch eight cycles; exp_rd/exp_wr are cycles after accept (0 = never).
  task automatic run_req(input string tag, input bit s, input int a, input int sz,
                         input logic [63:0] d, input int exp_rd, input int exp_wr,
                         input logic [63:0] exp_wd, input bit exp_err);
    int rdn = 0, wrn = 0, both = 0, rdc = 0, wrc = 0, dc = 0, misn = 0;
    logic rdy_after = 1'b0;
    logic [63:0] wd_at = '0, addr_at = '0;
    sel = s;
    @(negedge clk);
    check({tag, ".ready_in"}, o_rdy, 1'b1);
    addr = 14'(a); size = 3'(sz); data = d;
    if (s) v64 = 1'b1; else v32 = 1'b1;
    @(negedge clk);
    v32 = 1'b0; v64 = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (o_rd) begin rdn++; rdc = k; end
      if (o_wr) begin wrn++; wrc = k; addr_at = o_addr; end
      if (o_done) begin dc = k; wd_at = o_wd; end
      if (o_mis) misn++;
      if (o_rd && o_wr) both++;
      if (dc != 0 && k == dc + 1) rdy_after = o_rdy;
      @(negedge clk);
    end
    check({tag, ".rd_cnt"}, 64'(rdn), (exp_rd != 0) ? 64'd1 : 64'd0);
    if (exp_rd != 0) check({tag, ".rd_cyc"}, 64'(rdc), 64'(exp_rd));
    check({tag, ".wr_cnt"}, 64'(wrn), exp_err ? 64'd0 : 64'd1);
    check({tag, ".done_cyc"}, 64'(dc), exp_err ? 64'd1 : 64'(exp_wr));
    check({tag, ".mis_cnt"}, 64'(misn), exp_err ? 64'd1 : 64'd0);
    check({tag, ".rd_wr_overlap"}, 64'(both), 64'd0);
    check({tag, ".ready_after"}, rdy_after, 1'b1);
    if (!exp_err) begin
      check({tag, ".wr_cyc"}, 64'(wrc), 64'(exp_wr));
      check({tag, ".wr_data"}, wd_at, exp_wd);
      check({tag, ".wr_addr"}, addr_at, s ? 64'(a >> 3) : 64'(a >> 2));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int wn, dn, rn;
    ram32_word = 32'h11223344;
    ram64_word = 64'h0123456789ABCDEF;
    repeat (3) @(negedge clk);
    check("rst.ready", rdy32, 1'b1);
    check("rst.outs", {rd32, wr32, done32, mis32}, 4'b0);
    check("rst.wdata", wd32, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    run_req("byte_off3",  1'b0, 2*4+3, 0, 64'hAB,       1, 3, 64'hAB223344, 1'b0);
    run_req("half_off0",  1'b0, 3*4+0, 1, 64'hCAFEBEEF, 1, 3, 64'h1122BEEF, 1'b0);
    run_req("word_off0",  1'b0, 4*4+0, 2, 64'hDEADBEEF, 0, 1, 64'hDEADBEEF, 1'b0);
    run_req("half_off1",  1'b0, 1,     1, 64'h1234,     0, 0, 64'h0,        1'b1);
    run_req("word_off2",  1'b0, 2,     2, 64'h1234,     0, 0, 64'h0,        1'b1);
    run_req("dword_32",   1'b0, 0,     3, 64'h1234,     0, 0, 64'h0,        1'b1);
    run_req("half_off2",  1'b0, 5*4+2, 1, 64'h00001234, 1, 3, 64'h12343344, 1'b0);
    ram32_word = 32'hA5A5A5A5;
    run_req("byte_off1",  1'b0, 5*4+1, 0, 64'hFFFFFF77, 1, 3, 64'hA5A577A5, 1'b0);
    ram32_word = 32'h11223344;

    // Reset while waiting on read data: no write may follow.
    sel = 1'b0; wn = 0;
    @(negedge clk);
    addr = 14'(2*4+3); size = 3'd0; data = 64'hAB; v32 = 1'b1;
    @(negedge clk);
    v32 = 1'b0;
    check("rstwait.rd_en", rd32, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rstwait.outs", {rd32, wr32, done32, mis32}, 4'b0);
    check("rstwait.wdata", wd32, 32'h0);
    check("rstwait.addr", ra32, 11'h0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (wr32) wn++;
    end
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (wr32) wn++;
    end
    check("rstwait.no_wr", 64'(wn), 64'd0);
    check("rstwait.ready", rdy32, 1'b1);
    run_req("after_rst",  1'b0, 7*4+0, 0, 64'h9C,       1, 3, 64'h1122339C, 1'b0);

    // req_valid held: full-word stores accepted every other cycle.
    wn = 0; dn = 0; rn = 0;
    @(negedge clk);
    addr = 14'(6*4); size = 3'd2; data = 64'h0BADF00D; v32 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (wr32) wn++;
      if (done32) dn++;
      if (rd32) rn++;
    end
    v32 = 1'b0;
    check("b2b.done_cnt", 64'(dn), 64'd2);
    check("b2b.wr_cnt", 64'(wn), 64'd2);
    check("b2b.rd_cnt", 64'(rn), 64'd0);
    check("b2b.wdata", wd32, 32'h0BADF00D);
    repeat (3) @(negedge clk);

    run_req("w64_byte5",  1'b1, 1*8+5, 0, 64'h5A,       1, 5, 64'h01235A6789ABCDEF, 1'b0);
    run_req("w64_word4",  1'b1, 2*8+4, 2, 64'hFEEDFACE, 1, 5, 64'hFEEDFACE89ABCDEF, 1'b0);
    run_req("w64_full",   1'b1, 3*8,   3, 64'h1122334455667788, 0, 1, 64'h1122334455667788, 1'b0);
    run_req("w64_qword",  1'b1, 0,     4, 64'h1,        0, 0, 64'h0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
